hazard_ctrl_unit: RTL and testbench

- Pipeline controller that drives the 2:1 / 3:1 operand-select muxes and the pipeline-register enables of the 5-stage MIPS32 core.
- Produces EX-stage forwarding selects and the load-use stall.
- Handles the branch-taken flush.
- Sequences the multi-cycle multiply/divide unit (MDU) with a busy counter, stalling HI/LO readers and back-to-back MDU ops until the result is ready.

---
 rtl/hazard_ctrl_unit.sv | 156 +++++++++++++++
 tb/tb_hazard_ctrl_unit.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller for the 5-stage MIPS32 core: EX forwarding selects,
// load-use and MDU stalls, branch flush, and the multiply/divide busy sequencer.
module hazard_ctrl_unit #(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32,
    parameter int CNT_W       = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    input  logic       id_branch_taken,
    input  logic       id_mdu_start,
    input  logic       id_mdu_is_div,
    input  logic       id_hilo_read,
    input  logic [4:0] ex_rs,
    input  logic [4:0] ex_rt,
    input  logic [4:0] ex_rd,
    input  logic       ex_regwrite,
    input  logic       ex_memread,
    input  logic [4:0] mem_rd,
    input  logic       mem_regwrite,
    input  logic [4:0] wb_rd,
    input  logic       wb_regwrite,
    output logic [1:0] fwd_a_sel,
    output logic [1:0] fwd_b_sel,
    output logic       stall_if,
    output logic       stall_id,
    output logic       flush_id,
    output logic       flush_ex,
    output logic       mdu_launch,
    output logic       mdu_busy,
    output logic       mdu_done
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [1:0]       SEL_REG   = 2'b00;
    localparam logic [1:0]       SEL_WB    = 2'b01;
    localparam logic [1:0]       SEL_MEM   = 2'b10;
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;

    logic       busy_int;
    logic       done_int;
    logic       load_use;
    logic       mdu_hazard;
    logic       stall;
    logic       accept;
    logic [1:0] fwd_a_raw;
    logic [1:0] fwd_b_raw;

    // MEM is newer than WB, so it wins; register $0 is hardwired and never forwards.
    function automatic logic [1:0] fwd_select(
        input logic [4:0] src,
        input logic [4:0] m_rd,
        input logic       m_we,
        input logic [4:0] w_rd,
        input logic       w_we
    );
        logic [1:0] sel;
        sel = SEL_REG;
        if (m_we && (m_rd != 5'd0) && (m_rd == src)) begin
            sel = SEL_MEM;
        end else if (w_we && (w_rd != 5'd0) && (w_rd == src)) begin
            sel = SEL_WB;
        end
        return sel;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    always_comb begin
        busy_int   = (state == BUSY);
        done_int   = busy_int && (count == CNT_ONE);
        load_use   = ex_memread && (ex_rd != 5'd0) &&
                     ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
        mdu_hazard = busy_int && (id_hilo_read || id_mdu_start);
        stall      = load_use || mdu_hazard;
        accept     = (state == IDLE) && id_mdu_start && !load_use;
        fwd_a_raw  = fwd_select(ex_rs, mem_rd, mem_regwrite, wb_rd, wb_regwrite);
        fwd_b_raw  = fwd_select(ex_rt, mem_rd, mem_regwrite, wb_rd, wb_regwrite);
    end

    // The counter holds the number of busy cycles still to run, including the current one.
    always_comb begin
        state_next = state;
        count_next = count;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_next = BUSY;
                    count_next = id_mdu_is_div ? DIV_LOAD : MULT_LOAD;
                end
            end
            BUSY: begin
                count_next = count - CNT_ONE;
                if (done_int) begin
                    state_next = IDLE;
                    count_next = '0;
                end
            end
            default: begin
                state_next = IDLE;
                count_next = '0;
            end
        endcase
    end

    // Every output, combinational ones included, is forced low while reset is asserted.
    always_comb begin
        fwd_a_sel  = SEL_REG;
        fwd_b_sel  = SEL_REG;
        stall_if   = 1'b0;
        stall_id   = 1'b0;
        flush_id   = 1'b0;
        flush_ex   = 1'b0;
        mdu_launch = 1'b0;
        mdu_busy   = 1'b0;
        mdu_done   = 1'b0;
        if (!reset) begin
            fwd_a_sel  = fwd_a_raw;
            fwd_b_sel  = fwd_b_raw;
            stall_if   = stall;
            stall_id   = stall;
            flush_ex   = stall;
            flush_id   = id_branch_taken && !stall;
            mdu_launch = accept;
            mdu_busy   = busy_int;
            mdu_done   = done_int;
        end
    end

    // ex_regwrite is carried for interface completeness; load-use only needs ex_memread.
    logic unused_ok;
    assign unused_ok = ex_regwrite;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard testbench for hazard_ctrl_unit: expected output vectors are queued
// as each cycle's stimulus is driven and popped when the outputs are sampled.
module tb_hazard_ctrl_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
    logic       id_uses_rt, id_branch_taken, id_mdu_start, id_mdu_is_div, id_hilo_read;
    logic       ex_regwrite, ex_memread, mem_regwrite, wb_regwrite;
    logic [1:0] fwd_a_sel, fwd_b_sel;
    logic       stall_if, stall_id, flush_id, flush_ex, mdu_launch, mdu_busy, mdu_done;

    int checks = 0;
    int passed = 0;
    logic [12:0] sb[$];
    logic [12:0] got;
    logic [12:0] want;

    hazard_ctrl_unit #(.MULT_CYCLES(4), .DIV_CYCLES(32), .CNT_W(6)) dut (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_branch_taken(id_branch_taken), .id_mdu_start(id_mdu_start),
        .id_mdu_is_div(id_mdu_is_div), .id_hilo_read(id_hilo_read),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
        .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .stall_if(stall_if), .stall_id(stall_id), .flush_id(flush_id), .flush_ex(flush_ex),
        .mdu_launch(mdu_launch), .mdu_busy(mdu_busy), .mdu_done(mdu_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running, need finished");
        $fatal(1, "watchdog");
    end

    // Vector order: fwd_a, fwd_b, stall_if, stall_id, flush_id, flush_ex, launch, busy, done.
    function automatic logic [12:0] exp_vec(input logic [1:0] a, input logic [1:0] b,
                                            input logic stall, input logic fid,
                                            input logic launch, input logic busy,
                                            input logic done);
        return {a, b, stall, stall, fid, stall, launch, busy, done};
    endfunction

    function automatic logic [12:0] obs();
        return {fwd_a_sel, fwd_b_sel, stall_if, stall_id, flush_id, flush_ex,
                mdu_launch, mdu_busy, mdu_done};
    endfunction

    task automatic clear_inputs();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0; id_branch_taken = 1'b0;
        id_mdu_start = 1'b0; id_mdu_is_div = 1'b0; id_hilo_read = 1'b0;
        ex_rs = 5'd0; ex_rt = 5'd0; ex_rd = 5'd0; ex_regwrite = 1'b0; ex_memread = 1'b0;
        mem_rd = 5'd0; mem_regwrite = 1'b0; wb_rd = 5'd0; wb_regwrite = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        ex_rs = 5'd5; mem_rd = 5'd5; mem_regwrite = 1'b1; id_branch_taken = 1'b1;
        id_mdu_start = 1'b1;
        sb.push_back(exp_vec(2'b00, 2'b00, 0, 0, 0, 0, 0));
        @(negedge clk);
        got = obs(); want = sb.pop_front(); checks++;
        if (got !== want) $display("FAIL reset_outputs: got %b need %b", got, want);
        else passed++;
        next_cycle();
        reset = 1'b0;
        clear_inputs();
        sb.push_back(exp_vec(2'b00, 2'b00, 0, 0, 0, 0, 0));
        @(negedge clk);
        got = obs(); want = sb.pop_front(); checks++;
        if (got !== want) $display("FAIL reset_release_idle: got %b need %b", got, want);
        else passed++;
        next_cycle();
    endtask

    task automatic test_forwarding();
        logic [4:0]  rs_tab[4]  = '{5'd5, 5'd5, 5'd0, 5'd0};
        logic [4:0]  rt_tab[4]  = '{5'd7, 5'd9, 5'd9, 5'd5};
        logic [4:0]  mrd_tab[4] = '{5'd5, 5'd5, 5'd0, 5'd5};
        logic        mwe_tab[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic [4:0]  wrd_tab[4] = '{5'd5, 5'd9, 5'd0, 5'd5};
        logic        wwe_tab[4] = '{1'b1, 1'b1, 1'b1, 1'b1};
        logic [1:0]  a_tab[4]   = '{2'b10, 2'b00, 2'b00, 2'b00};
        logic [1:0]  b_tab[4]   = '{2'b00, 2'b01, 2'b00, 2'b10};
        for (int i = 0; i < 4; i++) begin
            clear_inputs();
            ex_rs = rs_tab[i]; ex_rt = rt_tab[i];
            mem_rd = mrd_tab[i]; mem_regwrite = mwe_tab[i];
            wb_rd = wrd_tab[i]; wb_regwrite = wwe_tab[i];
            sb.push_back(exp_vec(a_tab[i], b_tab[i], 0, 0, 0, 0, 0));
            @(negedge clk);
            got = obs(); want = sb.pop_front(); checks++;
            if (got !== want) $display("FAIL fwd_%0d: got %b need %b", i, got, want);
            else passed++;
            next_cycle();
        end
        // Same source, MEM write disabled: WB must supply it.
        clear_inputs();
        ex_rs = 5'd5; mem_rd = 5'd5; wb_rd = 5'd5; wb_regwrite = 1'b1;
        sb.push_back(exp_vec(2'b01, 2'b00, 0, 0, 0, 0, 0));
        @(negedge clk);
        got = obs(); want = sb.pop_front(); checks++;
        if (got !== want) $display("FAIL fwd_wb_fallback: got %b need %b", got, want);
        else passed++;
        next_cycle();
    endtask

    task automatic test_load_use();
        logic [4:0] erd_tab[5] = '{5'd8, 5'd8, 5'd8, 5'd8, 5'd0};
        logic [4:0] rs_tab[5]  = '{5'd1, 5'd1, 5'd1, 5'd8, 5'd0};
        logic [4:0] rt_tab[5]  = '{5'd8, 5'd8, 5'd8, 5'd2, 5'd0};
        logic       urt_tab[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic       mrd_tab[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic       st_tab[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            clear_inputs();
            ex_rd = erd_tab[i]; ex_memread = mrd_tab[i]; ex_regwrite = 1'b1;
            id_rs = rs_tab[i]; id_rt = rt_tab[i]; id_uses_rt = urt_tab[i];
            sb.push_back(exp_vec(2'b00, 2'b00, st_tab[i], 0, 0, 0, 0));
            @(negedge clk);
            got = obs(); want = sb.pop_front(); checks++;
            if (got !== want) $display("FAIL load_use_%0d: got %b need %b", i, got, want);
            else passed++;
            next_cycle();
        end
    endtask

    task automatic test_mult();
        for (int c = 0; c <= 6; c++) begin
            clear_inputs();
            id_mdu_start = (c == 0);
            id_hilo_read = (c >= 2 && c <= 5);
            sb.push_back(exp_vec(2'b00, 2'b00, (c >= 2 && c <= 4), 0,
                                 (c == 0), (c >= 1 && c <= 4), (c == 4)));
            @(negedge clk);
            got = obs(); want = sb.pop_front(); checks++;
            if (got !== want) $display("FAIL mult_cycle_%0d: got %b need %b", c, got, want);
            else passed++;
            next_cycle();
        end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c <= 38; c++) begin
            clear_inputs();
            id_mdu_start = (c <= 33);
            id_mdu_is_div = (c == 0);
            sb.push_back(exp_vec(2'b00, 2'b00, (c >= 1 && c <= 32), 0,
                                 (c == 0 || c == 33),
                                 ((c >= 1 && c <= 32) || (c >= 34 && c <= 37)),
                                 (c == 32 || c == 37)));
            @(negedge clk);
            got = obs(); want = sb.pop_front(); checks++;
            if (got !== want) $display("FAIL b2b_cycle_%0d: got %b need %b", c, got, want);
            else passed++;
            next_cycle();
        end
    endtask

    task automatic test_branch_stall();
        // Branch during a load-use stall, then released.
        for (int c = 0; c < 2; c++) begin
            clear_inputs();
            id_branch_taken = 1'b1; id_rs = 5'd3;
            ex_rd = 5'd3; ex_memread = (c == 0);
            sb.push_back(exp_vec(2'b00, 2'b00, (c == 0), (c == 1), 0, 0, 0));
            @(negedge clk);
            got = obs(); want = sb.pop_front(); checks++;
            if (got !== want) $display("FAIL branch_lu_%0d: got %b need %b", c, got, want);
            else passed++;
            next_cycle();
        end
        // MDU start blocked by load-use, launched next cycle; then branch under an MDU stall.
        for (int c = 0; c <= 6; c++) begin
            clear_inputs();
            id_rs = 5'd4; ex_rd = 5'd4; ex_memread = (c == 0);
            id_mdu_start = (c <= 1);
            id_branch_taken = (c == 2);
            id_hilo_read = (c == 2);
            sb.push_back(exp_vec(2'b00, 2'b00, (c == 0 || c == 2), 0,
                                 (c == 1), (c >= 2 && c <= 5), (c == 5)));
            @(negedge clk);
            got = obs(); want = sb.pop_front(); checks++;
            if (got !== want) $display("FAIL lu_start_branch_mh_%0d: got %b need %b", c, got, want);
            else passed++;
            next_cycle();
        end
    endtask

    task automatic test_reset_mid_div();
        for (int c = 0; c <= 10; c++) begin
            clear_inputs();
            id_mdu_start = (c == 0); id_mdu_is_div = 1'b1;
            sb.push_back(exp_vec(2'b00, 2'b00, 0, 0, (c == 0), (c >= 1), 0));
            @(negedge clk);
            got = obs(); want = sb.pop_front(); checks++;
            if (got !== want) $display("FAIL div_pre_reset_%0d: got %b need %b", c, got, want);
            else passed++;
            next_cycle();
        end
        clear_inputs();
        ex_rs = 5'd5; mem_rd = 5'd5; mem_regwrite = 1'b1; id_hilo_read = 1'b1;
        #2;
        reset = 1'b1;
        sb.push_back(exp_vec(2'b00, 2'b00, 0, 0, 0, 0, 0));
        #1;
        got = obs(); want = sb.pop_front(); checks++;
        if (got !== want) $display("FAIL async_reset_outputs: got %b need %b", got, want);
        else passed++;
        for (int c = 0; c < 3; c++) begin
            sb.push_back(exp_vec(2'b00, 2'b00, 0, 0, 0, 0, 0));
            @(negedge clk);
            got = obs(); want = sb.pop_front(); checks++;
            if (got !== want) $display("FAIL reset_hold_%0d: got %b need %b", c, got, want);
            else passed++;
        end
        next_cycle();
        reset = 1'b0;
        for (int c = 0; c <= 5; c++) begin
            clear_inputs();
            id_mdu_start = (c == 1);
            sb.push_back(exp_vec(2'b00, 2'b00, 0, 0, (c == 1), (c >= 2 && c <= 5), (c == 5)));
            @(negedge clk);
            got = obs(); want = sb.pop_front(); checks++;
            if (got !== want) $display("FAIL post_reset_mult_%0d: got %b need %b", c, got, want);
            else passed++;
            next_cycle();
        end
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        #1;
        test_reset();
        test_forwarding();
        test_load_use();
        test_mult();
        test_back_to_back();
        test_branch_stall();
        test_reset_mid_div();
        checks++;
        if (sb.size() != 0) $display("FAIL scoreboard_drain: got %0d left, need 0", sb.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
